// File: rtl/dht11_pkg.sv
// Shared definitions for the DHT11 single-wire sensor emulator and host reader:
// FSM state encoding, frame length, default protocol timing and the
// microsecond-to-cycle conversion.
package dht11_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HOST_LOW,
        ST_WAIT,
        ST_RESP_LOW,
        ST_RESP_HIGH,
        ST_BIT_LOW,
        ST_BIT_HIGH,
        ST_END_LOW
    } state_t;

    localparam int FRAME_BITS = 40;

    localparam int DEF_CLK_FREQ       = 12_000_000;
    localparam int DEF_T_START_MIN_US = 10000;
    localparam int DEF_T_WAIT_US      = 30;
    localparam int DEF_T_RESP_LOW_US  = 80;
    localparam int DEF_T_RESP_HIGH_US = 85;
    localparam int DEF_T_BIT_LOW_US   = 56;
    localparam int DEF_T_ZERO_HIGH_US = 26;
    localparam int DEF_T_ONE_HIGH_US  = 70;

    // Whole clocks per microsecond times the duration; CLK_FREQ is expected
    // to be an integer number of MHz.
    function automatic int us_to_cycles(input int freq, input int us);
        return (freq / 1_000_000) * us;
    endfunction

endpackage

// File: rtl/dht_line_sync.sv
// Two-flop synchronizer for the open-drain DHT data line. Resets to 1 because
// the released line is pulled high, so reset never looks like a start pulse.
module dht_line_sync (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic dout
);

    logic line_p0;

    // Double-register the asynchronous pad level into the clk domain
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            line_p0 <= 1'b1;
            dout    <= 1'b1;
        end else begin
            line_p0 <= din;
            dout    <= line_p0;
        end
    end

endmodule

// File: rtl/dht11_sensor_emulator.sv
// DHT11 sensor-side responder. Waits for a host start pulse, answers with the
// response preamble, sends rh_int, rh_dec, t_int, t_dec and checksum MSB first,
// then releases the line. Optional macro DHT11_EMU_CSUM_CORRUPT_EN adds the
// corrupt_csum input, which flips checksum bit 0 for host error-path testing.
module dht11_sensor_emulator
    import dht11_pkg::*;
#(
    parameter int CLK_FREQ       = DEF_CLK_FREQ,
    parameter int T_START_MIN_US = DEF_T_START_MIN_US,
    parameter int T_WAIT_US      = DEF_T_WAIT_US,
    parameter int T_RESP_LOW_US  = DEF_T_RESP_LOW_US,
    parameter int T_RESP_HIGH_US = DEF_T_RESP_HIGH_US,
    parameter int T_BIT_LOW_US   = DEF_T_BIT_LOW_US,
    parameter int T_ZERO_HIGH_US = DEF_T_ZERO_HIGH_US,
    parameter int T_ONE_HIGH_US  = DEF_T_ONE_HIGH_US
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       dq_in,
    output logic       dq_oe,
    input  logic [7:0] rh_int,
    input  logic [7:0] rh_dec,
    input  logic [7:0] t_int,
    input  logic [7:0] t_dec,
`ifdef DHT11_EMU_CSUM_CORRUPT_EN
    input  logic       corrupt_csum,
`endif
    output logic       busy,
    output logic       frame_done,
    output logic       short_start,
    output logic       collision
);

    localparam int N_START = us_to_cycles(CLK_FREQ, T_START_MIN_US);
    localparam int CNT_W   = $clog2(N_START + 1);

    // Phase end values are "last cycle of the phase" (N-1) since cnt starts at 0
    localparam logic [CNT_W-1:0] CNT_SAT       = CNT_W'(N_START);
    localparam logic [CNT_W-1:0] LIM_WAIT      = CNT_W'(us_to_cycles(CLK_FREQ, T_WAIT_US) - 1);
    localparam logic [CNT_W-1:0] LIM_RESP_LOW  = CNT_W'(us_to_cycles(CLK_FREQ, T_RESP_LOW_US) - 1);
    localparam logic [CNT_W-1:0] LIM_RESP_HIGH = CNT_W'(us_to_cycles(CLK_FREQ, T_RESP_HIGH_US) - 1);
    localparam logic [CNT_W-1:0] LIM_BIT_LOW   = CNT_W'(us_to_cycles(CLK_FREQ, T_BIT_LOW_US) - 1);
    localparam logic [CNT_W-1:0] LIM_ZERO      = CNT_W'(us_to_cycles(CLK_FREQ, T_ZERO_HIGH_US) - 1);
    localparam logic [CNT_W-1:0] LIM_ONE       = CNT_W'(us_to_cycles(CLK_FREQ, T_ONE_HIGH_US) - 1);
    // Early cycles of a high phase still show our own low through the synchronizer
    localparam logic [CNT_W-1:0] GUARD         = CNT_W'(3);
    localparam logic [5:0]       LAST_BIT      = 6'(FRAME_BITS - 1);

    function automatic logic [7:0] calc_csum(input logic [7:0] a, input logic [7:0] b,
                                             input logic [7:0] c, input logic [7:0] d);
        logic [9:0] sum;
        sum = {2'b00, a} + {2'b00, b} + {2'b00, c} + {2'b00, d};
        return sum[7:0];
    endfunction

    state_t                state, state_next;
    logic [CNT_W-1:0]      cnt;
    logic [5:0]            bit_idx;
    logic [FRAME_BITS-1:0] frame_sr;
    logic                  dq_sync;
    logic                  corrupt;
    logic [7:0]            csum;
    logic [CNT_W-1:0]      bit_lim;
    logic                  collide;
    logic                  dq_oe_next, busy_next, frame_done_next, short_start_next, collision_next;

    dht_line_sync u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (dq_in),
        .dout    (dq_sync)
    );

`ifdef DHT11_EMU_CSUM_CORRUPT_EN
    assign corrupt = corrupt_csum;
`else
    assign corrupt = 1'b0;
`endif

    assign csum    = calc_csum(rh_int, rh_dec, t_int, t_dec) ^ {7'd0, corrupt};
    assign bit_lim = frame_sr[FRAME_BITS-1] ? LIM_ONE : LIM_ZERO;
    assign collide = ((state == ST_RESP_HIGH) || (state == ST_BIT_HIGH))
                     && (cnt >= GUARD) && !dq_sync;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_next;
    end

    // Next-state decode
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:      if (!dq_sync) state_next = ST_HOST_LOW;
            ST_HOST_LOW:  if (dq_sync) state_next = (cnt == CNT_SAT) ? ST_WAIT : ST_IDLE;
            ST_WAIT:      if (!dq_sync)              state_next = ST_HOST_LOW;
                          else if (cnt == LIM_WAIT)  state_next = ST_RESP_LOW;
            ST_RESP_LOW:  if (cnt == LIM_RESP_LOW)   state_next = ST_RESP_HIGH;
            ST_RESP_HIGH: if (collide)               state_next = ST_IDLE;
                          else if (cnt == LIM_RESP_HIGH) state_next = ST_BIT_LOW;
            ST_BIT_LOW:   if (cnt == LIM_BIT_LOW)    state_next = ST_BIT_HIGH;
            ST_BIT_HIGH:  if (collide)               state_next = ST_IDLE;
                          else if (cnt == bit_lim)
                              state_next = (bit_idx == LAST_BIT) ? ST_END_LOW : ST_BIT_LOW;
            ST_END_LOW:   if (cnt == LIM_BIT_LOW)    state_next = ST_IDLE;
            default:      state_next = ST_IDLE;
        endcase
    end

    // Output decode from the upcoming state so registered outputs align with it
    always_comb begin
        dq_oe_next       = (state_next == ST_RESP_LOW) || (state_next == ST_BIT_LOW)
                           || (state_next == ST_END_LOW);
        busy_next        = !((state_next == ST_IDLE) || (state_next == ST_HOST_LOW));
        frame_done_next  = (state == ST_END_LOW) && (state_next == ST_IDLE);
        short_start_next = (state == ST_HOST_LOW) && (state_next == ST_IDLE);
        collision_next   = collide;
    end

    // Output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dq_oe       <= 1'b0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            short_start <= 1'b0;
            collision   <= 1'b0;
        end else begin
            dq_oe       <= dq_oe_next;
            busy        <= busy_next;
            frame_done  <= frame_done_next;
            short_start <= short_start_next;
            collision   <= collision_next;
        end
    end

    // Phase counter (restarts on every state change, saturates for long host lows) and bit index
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt     <= '0;
            bit_idx <= '0;
        end else begin
            if ((state_next != state) || (state == ST_IDLE)) cnt <= '0;
            else if (cnt != CNT_SAT)                          cnt <= cnt + 1'b1;

            if (state == ST_RESP_HIGH)
                bit_idx <= '0;
            else if ((state == ST_BIT_HIGH) && (state_next == ST_BIT_LOW))
                bit_idx <= bit_idx + 1'b1;
        end
    end

    // Frame shift register: loaded once at start acceptance, shifted after each bit
    always_ff @(posedge clk) begin
        if ((state == ST_HOST_LOW) && (state_next == ST_WAIT))
            frame_sr <= {rh_int, rh_dec, t_int, t_dec, csum};
        else if ((state == ST_BIT_HIGH) && (state_next == ST_BIT_LOW))
            frame_sr <= {frame_sr[FRAME_BITS-2:0], 1'b0};
    end

endmodule

// File: tb/tb_dht11_sensor_emulator.sv
// Bench for dht11_sensor_emulator. Runs the DUT at 1 MHz (one cycle per
// microsecond) with a 200 us start threshold to keep runs short; host lows of
// 360 and 100 cycles stand in for the 18 ms and 5 ms pulses.
module tb_dht11_sensor_emulator;

    localparam int CLK_FREQ   = 1_000_000;
    localparam int T_START    = 200;
    localparam int CPU        = CLK_FREQ / 1_000_000;
    localparam int N_WAIT     = CPU * 30;
    localparam int N_RL       = CPU * 80;
    localparam int N_RH       = CPU * 85;
    localparam int N_BL       = CPU * 56;
    localparam int N_ZERO     = CPU * 26;
    localparam int N_ONE      = CPU * 70;
    localparam int HOST_LONG  = CPU * 360;
    localparam int HOST_SHORT = CPU * 100;
    localparam int BOUND      = 20000;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       host_low = 1'b0;
    logic       dq_in, dq_oe, busy, frame_done, short_start, collision;
    logic [7:0] rh_int = 8'h00, rh_dec = 8'h00, t_int = 8'h00, t_dec = 8'h00;
`ifdef DHT11_EMU_CSUM_CORRUPT_EN
    logic       corrupt_csum = 1'b0;
`endif

    int checks = 0, failures = 0;
    int n_done = 0, n_short = 0, n_coll = 0, n_oe = 0, n_busy = 0;

    // Open-drain line: low if either the host or the DUT pulls it
    assign dq_in = !(host_low || dq_oe);

    always #5 clk = ~clk;

    dht11_sensor_emulator #(
        .CLK_FREQ       (CLK_FREQ),
        .T_START_MIN_US (T_START)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .dq_in        (dq_in),
        .dq_oe        (dq_oe),
        .rh_int       (rh_int),
        .rh_dec       (rh_dec),
        .t_int        (t_int),
        .t_dec        (t_dec),
`ifdef DHT11_EMU_CSUM_CORRUPT_EN
        .corrupt_csum (corrupt_csum),
`endif
        .busy         (busy),
        .frame_done   (frame_done),
        .short_start  (short_start),
        .collision    (collision)
    );

    // Event counters sampled away from the active edge
    always @(negedge clk) begin
        if (frame_done === 1'b1)  n_done++;
        if (short_start === 1'b1) n_short++;
        if (collision === 1'b1)   n_coll++;
        if (dq_oe === 1'b1)       n_oe++;
        if (busy === 1'b1)        n_busy++;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference frame: four bytes then their 8-bit sum, optionally with bit 0 flipped
    function automatic logic [39:0] model_frame(input logic [7:0] a, input logic [7:0] b,
                                                input logic [7:0] c, input logic [7:0] d,
                                                input logic bad);
        int s;
        logic [7:0] cs;
        s  = (int'(a) + int'(b) + int'(c) + int'(d)) % 256;
        cs = 8'(s);
        if (bad) cs[0] = ~cs[0];
        return {a, b, c, d, cs};
    endfunction

    task automatic set_bytes(input logic [7:0] a, input logic [7:0] b,
                             input logic [7:0] c, input logic [7:0] d);
        rh_int = a; rh_dec = b; t_int = c; t_dec = d;
    endtask

    task automatic host_start(input int len);
        host_low = 1'b1;
        repeat (len) @(negedge clk);
        host_low = 1'b0;
    endtask

    task automatic wait_oe_high(output int d);
        d = 0;
        while (dq_oe !== 1'b1 && d < BOUND) begin
            @(negedge clk);
            d++;
        end
    endtask

    // Length in cycles of the current dq_oe phase; returns at the first cycle of the next one
    task automatic measure(input logic level, output int len);
        len = 0;
        while (dq_oe === level && len < BOUND) begin
            @(negedge clk);
            len++;
        end
    endtask

    task automatic recv_frame(input string tag, input logic [39:0] exp);
        int d, len, bad_low, bad_high, done0;
        logic [39:0] got;
        wait_oe_high(d);
        check({tag, " resp_delay_in_range"}, 64'((d >= N_WAIT) && (d <= N_WAIT + 4)), 64'd1);
        check({tag, " busy_at_resp"}, 64'(busy), 64'd1);
        measure(1'b1, len);
        check({tag, " resp_low_len"}, 64'(len), 64'(N_RL));
        measure(1'b0, len);
        check({tag, " resp_high_len"}, 64'(len), 64'(N_RH));
        bad_low = 0; bad_high = 0; got = '0;
        for (int i = 0; i < 40; i++) begin
            measure(1'b1, len);
            if (len != N_BL) bad_low++;
            measure(1'b0, len);
            got = {got[38:0], (len > (N_ZERO + N_ONE) / 2)};
            if (len != (exp[39-i] ? N_ONE : N_ZERO)) bad_high++;
        end
        check({tag, " frame_data"}, 64'(got), 64'(exp));
        check({tag, " bit_low_errors"}, 64'(bad_low), 64'd0);
        check({tag, " bit_high_errors"}, 64'(bad_high), 64'd0);
        done0 = n_done;
        measure(1'b1, len);
        check({tag, " end_low_len"}, 64'(len), 64'(N_BL));
        check({tag, " done_busy_at_release"}, 64'({frame_done, busy}), 64'b10);
        repeat (3) @(negedge clk);
        check({tag, " frame_done_pulses"}, 64'(n_done - done0), 64'd1);
    endtask

    initial begin
        int d, len, s0, o0, b0, c0, d0;
        logic [39:0] exp1;

        repeat (3) @(negedge clk);
        check("reset_outputs", 64'({dq_oe, busy, frame_done, short_start, collision}), 64'd0);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        check("idle_outputs", 64'({dq_oe, busy}), 64'd0);

        // Nominal frame
        set_bytes(8'h37, 8'h00, 8'h19, 8'h05);
        host_start(HOST_LONG);
        recv_frame("nominal", 40'h37_00_19_05_55);

        // Short start pulse
        repeat (20) @(negedge clk);
        s0 = n_short; o0 = n_oe; b0 = n_busy;
        host_start(HOST_SHORT);
        repeat (10) @(negedge clk);
        check("short_start_pulses", 64'(n_short - s0), 64'd1);
        check("short_dq_oe_cycles", 64'(n_oe - o0), 64'd0);
        check("short_busy_cycles", 64'(n_busy - b0), 64'd0);

        // Collision 20 cycles into the high phase of bit 7
        repeat (20) @(negedge clk);
        host_start(HOST_LONG);
        wait_oe_high(d);
        measure(1'b1, len);
        measure(1'b0, len);
        for (int i = 0; i < 7; i++) begin
            measure(1'b1, len);
            measure(1'b0, len);
        end
        measure(1'b1, len);
        repeat (20) @(negedge clk);
        c0 = n_coll; d0 = n_done;
        host_low = 1'b1;
        repeat (4) @(negedge clk);
        check("collision_pulses", 64'(n_coll - c0), 64'd1);
        check("collision_outputs", 64'({dq_oe, busy}), 64'd0);
        repeat (5) @(negedge clk);
        host_low = 1'b0;
        o0 = n_oe;
        repeat (200) @(negedge clk);
        check("collision_line_released", 64'(n_oe - o0), 64'd0);
        check("collision_no_frame_done", 64'(n_done - d0), 64'd0);

        // Asynchronous reset during the response low phase
        repeat (20) @(negedge clk);
        host_start(HOST_LONG);
        wait_oe_high(d);
        repeat (10) @(negedge clk);
        #1 reset_n = 1'b0;
        #1 check("reset_midframe_async", 64'({dq_oe, busy}), 64'd0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        set_bytes(8'h21, 8'h08, 8'h1E, 8'h03);
        host_start(HOST_LONG);
        recv_frame("after_reset", model_frame(8'h21, 8'h08, 8'h1E, 8'h03, 1'b0));

        // Back-to-back: inputs change mid-frame, second request 1 ms after frame_done
        set_bytes(8'h12, 8'h34, 8'h56, 8'h78);
        exp1 = model_frame(8'h12, 8'h34, 8'h56, 8'h78, 1'b0);
        host_start(HOST_LONG);
        fork
            recv_frame("b2b_first", exp1);
            begin
                repeat (300) @(negedge clk);
                set_bytes(8'hFF, 8'hFF, 8'hFF, 8'hFF);
            end
        join
        repeat (1000 * CPU) @(negedge clk);
        host_start(HOST_LONG);
        recv_frame("b2b_second", 40'hFF_FF_FF_FF_FC);

        // Random payloads, each request issued right after the previous frame
        for (int k = 0; k < 2; k++) begin
            set_bytes(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                      8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
            host_start(HOST_LONG);
            recv_frame("random", model_frame(rh_int, rh_dec, t_int, t_dec, 1'b0));
        end

`ifdef DHT11_EMU_CSUM_CORRUPT_EN
        set_bytes(8'h37, 8'h00, 8'h19, 8'h05);
        corrupt_csum = 1'b1;
        host_start(HOST_LONG);
        recv_frame("corrupt_csum", 40'h37_00_19_05_54);
        corrupt_csum = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dht11_sensor_emulator.md
Name: dht11_sensor_emulator

Overview:
- Single-wire DHT11 responder: the sensor end of the protocol.
- Detects a host start pulse on the open-drain data line, answers with the response preamble, then sends a 40-bit frame (rh_int, rh_dec, t_int, t_dec, checksum) and releases the line.
- Used on-board for loopback and bring-up of the DHT11 host reader, and in simulation as a sensor model.
- The pad buffer (SB_IO, pull-up) lives in the top level. This block only sees the synchronized input and a drive-low enable.

Parameters:
- CLK_FREQ, 12_000_000, clock frequency in Hz.
- T_START_MIN_US, 10000, minimum host low time accepted as a start request.
- T_WAIT_US, 30, delay from host release (line high) to response low.
- T_RESP_LOW_US, 80, response low phase.
- T_RESP_HIGH_US, 85, response high phase.
- T_BIT_LOW_US, 56, low preamble before every data bit and the final end-of-frame low.
- T_ZERO_HIGH_US, 26, high time encoding 0.
- T_ONE_HIGH_US, 70, high time encoding 1.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  reset, asynchronous, active-low.
- dq_in  in  1  raw data-line level from the pad, asynchronous.
- dq_oe  out  1  1 = drive line low; 0 = release (pull-up).
- rh_int  in  8  humidity integer byte.
- rh_dec  in  8  humidity decimal byte.
- t_int  in  8  temperature integer byte.
- t_dec  in  8  temperature decimal byte.
- busy  out  1  high from start acceptance until the line is released after the frame.
- frame_done  out  1  one-cycle pulse when a full frame has been sent.
- short_start  out  1  one-cycle pulse when a host low pulse is shorter than T_START_MIN_US.
- collision  out  1  one-cycle pulse when the line reads low while the block is releasing it in a high phase.

Behaviour:
- Reset: dq_oe=0, busy=0, frame_done=0, short_start=0, collision=0, state IDLE. Reset asserted mid-frame releases the line immediately (async).
- dq_in passes a 2-FF synchronizer, giving 2 cycles of input latency. All outputs are registered.
- Cycle counts: N(T) = (CLK_FREQ/1_000_000)*T. Each drive phase holds dq_oe constant for exactly N cycles.
- Counter width is $clog2(N(T_START_MIN_US)+1). The counter saturates in HOST_LOW.
- States and transitions:
  - IDLE: on sync low, go to HOST_LOW with counter=0.
  - HOST_LOW: count while low.
    - Line goes high with count < N(T_START_MIN_US): pulse short_start, return to IDLE.
    - Line goes high otherwise: latch the 4 data bytes and the checksum, set busy=1, go to WAIT.
  - WAIT: N(T_WAIT_US) cycles released, then RESP_LOW.
    - A low seen in WAIT is treated as the host restarting: go to HOST_LOW, busy=0.
  - RESP_LOW: dq_oe=1 for N(T_RESP_LOW_US), then RESP_HIGH.
  - RESP_HIGH: dq_oe=0 for N(T_RESP_HIGH_US), then BIT_LOW with bit_idx=0.
  - BIT_LOW: dq_oe=1 for N(T_BIT_LOW_US), then BIT_HIGH.
  - BIT_HIGH: dq_oe=0 for N(T_ZERO_HIGH_US) or N(T_ONE_HIGH_US), per frame bit.
    - bit_idx < 39: increment bit_idx, go to BIT_LOW.
    - bit_idx == 39: go to END_LOW.
  - END_LOW: dq_oe=1 for N(T_BIT_LOW_US), then release.
    - Pulse frame_done and clear busy in the same cycle dq_oe falls.
    - Go to IDLE.
- Frame order and arithmetic:
  - Bits go out MSB first, bytes in order rh_int, rh_dec, t_int, t_dec, checksum.
  - checksum = (rh_int+rh_dec+t_int+t_dec) mod 256, 8-bit truncation.
- Data latching: bytes are latched once per frame at start acceptance. Input changes during a frame have no effect.
- Collision: in RESP_HIGH or BIT_HIGH, ignoring the first 3 cycles of the phase for sync/rise latency:
  - A sync low pulses collision, sets dq_oe=0 and busy=0, and goes to IDLE.
  - No frame_done.
- Back-to-back requests: IDLE accepts a new start on the first cycle after END_LOW. There is no holdoff.

Optional Feature:
- Macro: DHT11_EMU_CSUM_CORRUPT_EN.
- Defined:
  - Adds input corrupt_csum (1 bit), sampled at start acceptance.
  - When 1, the transmitted checksum has bit 0 inverted; used for host error-path tests.
- Undefined: the port is absent and the checksum is always correct.

Decomposition:
- Package dht11_pkg holds:
  - the state enum;
  - the us_to_cycles(freq, us) constant function;
  - FRAME_BITS=40;
  - default timing constants, shared with the host reader.
- Sub-module dht_line_sync: the 2-FF synchronizer with reset value 1 (idle-high line), reusable by the host.

Test Plan:
- Nominal frame: host low 18 ms then release; bytes 0x37,0x00,0x19,0x05 -> checksum 0x55.
  - Response low 960 cycles and high 1020 cycles.
  - 40 bits decoded as 0x37001905_55, bit lows 672 cycles, highs 312 (0) or 840 (1).
  - frame_done pulses once; busy falls with it.
- Short start: host low 5 ms -> short_start pulse, dq_oe stays 0, busy stays 0.
- Collision: bench forces the line low 20 µs into bit 7 high -> collision pulse, dq_oe=0 the next cycle, IDLE, no frame_done.
- Reset mid-frame: reset_n low during RESP_LOW -> dq_oe=0 immediately. After release, a fresh 18 ms start yields a full correct frame.
- Back-to-back: two start requests, the second 1 ms after frame_done, bytes changed to 0xFF×4 -> second frame checksum 0xFC, first frame unaffected.
- With DHT11_EMU_CSUM_CORRUPT_EN and corrupt_csum=1, bytes 0x37,0x00,0x19,0x05 -> transmitted checksum 0x54.
